// File: rtl/addsub_rr_sched_pkg.sv
// Shared definitions for the round-robin add/sub scheduler.
//   - default sizing constants (requesters, operand width, id width)
//   - FSM state encoding
//   - rr_grant(): one-hot round-robin winner from a valid vector and the last-granted index
package addsub_rr_sched_pkg;

  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefWidth = 20;
  localparam int unsigned DefIdw   = 2;
  // Upper bound on requesters; rr_grant works on vectors of this width.
  localparam int unsigned MaxReq   = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

  // Scan last+1, last+2, ... (mod nreq) and grant the first valid index.
  function automatic logic [MaxReq-1:0] rr_grant(input logic [MaxReq-1:0] valid,
                                                  input int unsigned       last,
                                                  input int unsigned       nreq);
    logic [MaxReq-1:0] gnt;
    logic              found;
    logic [2:0]        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      if (k <= nreq) begin
        idx = 3'((last + k) % nreq);
        if (!found && valid[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/cla20d.sv
// Carry-lookahead add/subtract unit (parallel-prefix carries).
//   a_i, b_i : operands, MSB+1 bits
//   sub_i    : 0 = a+b, 1 = a-b (b inverted, carry-in set)
//   sum_o    : result modulo 2^(MSB+1)
module cla20d #(
  parameter int unsigned MSB = 19
) (
  input  logic [MSB:0] a_i,
  input  logic [MSB:0] b_i,
  input  logic         sub_i,
  output logic [MSB:0] sum_o
);

  localparam int unsigned W  = MSB + 1;
  localparam int unsigned Ns = $clog2(W);

  logic [W-1:0] bx;
  logic [W-1:0] g0;
  logic [W-1:0] p0;
  logic [W-1:0] gk;
  logic [W-1:0] pk;
  logic [W-1:0] carry;

  assign bx = b_i ^ {W{sub_i}};
  assign g0 = a_i & bx;
  assign p0 = a_i ^ bx;

  // Kogge-Stone prefix: after all stages gk[i]/pk[i] are the group generate/propagate over
  // bits [i:0]. Descending index order keeps lower bits at their previous-stage values.
  always_comb begin
    gk = g0;
    pk = p0;
    for (int s = 0; s < int'(Ns); s++) begin
      for (int i = int'(W) - 1; i >= (1 << s); i--) begin
        gk[i] = gk[i] | (pk[i] & gk[i - (1 << s)]);
        pk[i] = pk[i] & pk[i - (1 << s)];
      end
    end
  end

  // Carry into bit i comes from the prefix over [i-1:0] plus the carry-in.
  assign carry = {gk[W-2:0], 1'b0} | ({pk[W-2:0], 1'b1} & {W{sub_i}});
  assign sum_o = p0 ^ carry;

endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one carry-lookahead add/sub unit between NREQ requesters.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (at most one ready bit high)
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub             : per-requester op select (0 add, 1 subtract)
//   rsp_valid/rsp_ready : single response channel with backpressure
//   rsp_id, rsp_data    : owner of the result and the result itself
//   rsp_ovf             : signed overflow of the operation
//   busy                : high whenever the FSM is not idle
module addsub_rr_sched
  import addsub_rr_sched_pkg::*;
#(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned IDW   = DefIdw
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_ovf,
  output logic                  busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]  a_q, b_q;
  logic              sub_q;
  logic [IDW-1:0]    id_q;
  logic [IDW-1:0]    last_q;

  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              rsp_ovf_q;

  logic [MaxReq-1:0] valid_ext;
  logic [MaxReq-1:0] gnt_ext;
  logic [NREQ-1:0]   gnt;
  logic              unused_gnt;
  logic [IDW-1:0]    gnt_id;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              sel_sub;

  logic              accept, capture, retire;
  logic [WIDTH-1:0]  sum;
  logic              ovf;

  // Arbitration
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = req_valid;
  end

  assign gnt_ext    = rr_grant(valid_ext, 32'(last_q), NREQ);
  assign gnt        = gnt_ext[NREQ-1:0];
  assign unused_gnt = ^gnt_ext;

  always_comb begin
    gnt_id  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_id  = IDW'(i);
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_sub = req_sub[i];
      end
    end
  end

  // FSM next state and handshake outputs. The !rst terms keep req_ready low while reset is
  // asserted, since the idle state would otherwise grant combinationally.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rst && |req_valid) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          retire = 1'b1;
          if (!rst && |req_valid) begin
            // Retire and accept in the same cycle for back-to-back operation.
            req_ready = gnt;
            accept    = 1'b1;
            state_d   = StCalc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shared adder and signed-overflow detection
  cla20d #(
    .MSB (WIDTH - 1)
  ) u_cla (
    .a_i   (a_q),
    .b_i   (b_q),
    .sub_i (sub_q),
    .sum_o (sum)
  );

  assign ovf = (sub_q ? (a_q[WIDTH-1] != b_q[WIDTH-1]) : (a_q[WIDTH-1] == b_q[WIDTH-1])) &
               (sum[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= '0;
      last_q      <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        sub_q  <= sel_sub;
        id_q   <= gnt_id;
        last_q <= gnt_id;
      end
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_data_q  <= sum;
        rsp_ovf_q   <= ovf;
      end else if (retire) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Self-checking bench for addsub_rr_sched: directed scenarios plus randomized operands,
// checked against an arithmetic reference model and a round-robin pick model.
module tb_addsub_rr_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 20;
  localparam int unsigned IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ovf;
  logic                  busy;

  addsub_rr_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mdl_last;

  // Reference model: plain signed arithmetic
  function automatic longint to_signed(input logic [WIDTH-1:0] v);
    longint r;
    r = longint'(v);
    if (v[WIDTH-1]) r = r - (longint'(1) << WIDTH);
    return r;
  endfunction

  function automatic longint mdl_math(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic s);
    return s ? to_signed(a) - to_signed(b) : to_signed(a) + to_signed(b);
  endfunction

  function automatic logic [WIDTH-1:0] mdl_res(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic s);
    return WIDTH'(mdl_math(a, b, s));
  endfunction

  function automatic logic mdl_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
    longint r;
    r = mdl_math(a, b, s);
    return (r < -(longint'(1) << (WIDTH - 1))) || (r > (longint'(1) << (WIDTH - 1)) - 1);
  endfunction

  // First valid requester after the last grant, wrapping around
  function automatic int mdl_pick(input logic [NREQ-1:0] v);
    int idx;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = (mdl_last + k) % int'(NREQ);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
    req_a[r*WIDTH +: WIDTH] = a;
    req_b[r*WIDTH +: WIDTH] = b;
    req_sub[r]              = s;
    req_valid[r]            = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 20'h7FFFF;
      1:       return 20'h80000;
      2:       return 20'h00000;
      3:       return 20'hFFFFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic check_rsp(input string tag, input int id, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic s);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_data"},  32'(rsp_data),  32'(mdl_res(a, b, s)));
    chk({tag, "_ovf"},   32'(rsp_ovf),   32'(mdl_ovf(a, b, s)));
  endtask

  // One isolated operation from idle with rsp_ready held high; checks the n / n+2 timing.
  task automatic single(input string tag, input int r, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s);
    int w;
    set_req(r, a, b, s);
    #1;
    w = mdl_pick(req_valid);
    chk({tag, "_rdy"}, 32'(req_ready), 32'(1) << w);
    mdl_last = w;
    step();
    req_valid[r] = 1'b0;
    chk({tag, "_calc_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_calc_busy"},  32'(busy),      32'd1);
    step();
    check_rsp(tag, r, a, b, s);
    step();
    chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle_busy"},  32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    mdl_last = int'(NREQ) - 1;
    step();
    #2;
    rst = 1'b0;
    step();
  endtask

  logic [WIDTH-1:0] ha, hb, fa [NREQ], fb [NREQ];
  logic             hs, fs [NREQ];
  int               w;

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    mdl_last  = int'(NREQ) - 1;

    // Reset state, with requests pending to show req_ready is held low
    step();
    step();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_data",  32'(rsp_data),  32'd0);
    chk("rst_ovf",   32'(rsp_ovf),   32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    #2;
    rst = 1'b0;
    step();

    // Directed arithmetic
    single("add",      0, 20'h00005, 20'h00003, 1'b0);
    single("sub_neg",  1, 20'h00003, 20'h00005, 1'b1);
    single("add_ovf",  2, 20'h7FFFF, 20'h00001, 1'b0);
    single("sub_ovf",  3, 20'h80000, 20'h00001, 1'b1);
    single("sub_min",  0, 20'h00000, 20'h80000, 1'b1);
    single("add_min",  1, 20'h80000, 20'h80000, 1'b0);

    // Randomized single operations
    for (int n = 0; n < 24; n++) begin
      single("rnd", int'($urandom_range(0, NREQ - 1)), rnd_op(), rnd_op(), 1'($urandom));
    end

    // Fairness: everyone requesting, back-to-back grants every 2 cycles
    do_reset();
    for (int r = 0; r < int'(NREQ); r++) begin
      fa[r] = rnd_op();
      fb[r] = rnd_op();
      fs[r] = 1'($urandom);
      set_req(r, fa[r], fb[r], fs[r]);
    end
    #1;
    for (int k = 0; k < 6; k++) begin
      w = mdl_pick(req_valid);
      chk("fair_rdy", 32'(req_ready), 32'(1) << w);
      ha = fa[w];
      hb = fb[w];
      hs = fs[w];
      mdl_last = w;
      step();
      fa[w] = rnd_op();
      fb[w] = rnd_op();
      fs[w] = 1'($urandom);
      set_req(w, fa[w], fb[w], fs[w]);
      chk("fair_calc_valid", 32'(rsp_valid), 32'd0);
      step();
      check_rsp("fair", w, ha, hb, hs);
    end
    req_valid = '0;
    step();
    chk("fair_end_valid", 32'(rsp_valid), 32'd0);
    chk("fair_end_busy",  32'(busy),      32'd0);

    // Backpressure: response held for 5 cycles, then retire + accept req 2 together
    rsp_ready = 1'b0;
    ha = rnd_op();
    hb = rnd_op();
    hs = 1'($urandom);
    set_req(1, ha, hb, hs);
    #1;
    w = mdl_pick(req_valid);
    chk("bp_rdy1", 32'(req_ready), 32'(1) << w);
    mdl_last = w;
    step();
    req_valid[1] = 1'b0;
    set_req(2, 20'h12345, 20'h0ABCD, 1'b1);
    step();
    for (int c = 0; c < 5; c++) begin
      check_rsp("bp_hold", 1, ha, hb, hs);
      chk("bp_hold_rdy", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    w = mdl_pick(req_valid);
    chk("bp_rdy2", 32'(req_ready), 32'(1) << w);
    mdl_last = w;
    step();
    req_valid[2] = 1'b0;
    chk("bp_retired",  32'(rsp_valid), 32'd0);
    chk("bp_calc_busy", 32'(busy),     32'd1);
    step();
    check_rsp("bp_next", 2, 20'h12345, 20'h0ABCD, 1'b1);
    step();

    // Priority skips idle requesters: last grant 1, only 0 and 3 valid
    single("pre_skip", 1, 20'h00010, 20'h00020, 1'b0);
    set_req(0, 20'h00100, 20'h00001, 1'b1);
    set_req(3, 20'h00200, 20'h00002, 1'b0);
    #1;
    w = mdl_pick(req_valid);
    chk("skip_rdy3", 32'(req_ready), 32'(1) << w);
    mdl_last = w;
    step();
    req_valid[3] = 1'b0;
    step();
    check_rsp("skip_rsp3", 3, 20'h00200, 20'h00002, 1'b0);
    w = mdl_pick(req_valid);
    chk("skip_rdy0", 32'(req_ready), 32'(1) << w);
    mdl_last = w;
    step();
    req_valid[0] = 1'b0;
    step();
    check_rsp("skip_rsp0", 0, 20'h00100, 20'h00001, 1'b1);
    step();

    // Reset in the middle of CALC drops the operation
    set_req(1, 20'h00777, 20'h00111, 1'b0);
    #1;
    chk("mid_rdy", 32'(req_ready), 32'd2);
    step();
    req_valid[1] = 1'b0;
    set_req(0, 20'h00009, 20'h00004, 1'b1);
    set_req(2, 20'h00008, 20'h00002, 1'b0);
    #3;
    rst = 1'b1;
    mdl_last = int'(NREQ) - 1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_data",  32'(rsp_data),  32'd0);
    chk("mid_rst_id",    32'(rsp_id),    32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_rdy",   32'(req_ready), 32'd0);
    step();
    chk("mid_rst_hold",  32'(rsp_valid), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    w = mdl_pick(req_valid);
    chk("post_rst_rdy0", 32'(req_ready), 32'(1) << w);
    mdl_last = w;
    step();
    req_valid[0] = 1'b0;
    chk("post_rst_calc", 32'(rsp_valid), 32'd0);
    step();
    check_rsp("post_rst_rsp0", 0, 20'h00009, 20'h00004, 1'b1);
    w = mdl_pick(req_valid);
    chk("post_rst_rdy2", 32'(req_ready), 32'(1) << w);
    mdl_last = w;
    step();
    req_valid[2] = 1'b0;
    step();
    check_rsp("post_rst_rsp2", 2, 20'h00008, 20'h00002, 1'b0);
    step();
    chk("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_rr_sched.md
Name: addsub_rr_sched

Overview:
- Round-robin scheduler that shares one 20-bit carry-lookahead add/subtract unit between NREQ requesters.
- Accepts operand pairs and an add/sub select over per-requester valid/ready handshakes, and registers the operands.
- Drives the shared adder and returns a tagged, registered result with signed-overflow flag on a single response channel with backpressure.
- Sits between the arithmetic clients of the datapath and the shared add/sub unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 20, operand/result width in bits. Must match the shared adder; the adder's MSB-index parameter is WIDTH-1.
- IDW, 2, width of the requester ID; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high in any cycle.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_sub  in  NREQ  0 = A+B, 1 = A-B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  WIDTH  result, two's complement modulo 2^WIDTH.
- rsp_ovf  out  1  signed overflow.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, busy=0, req_ready=0.
  - Operand registers are cleared.
  - Round-robin pointer last=NREQ-1, so requester 0 has the highest priority after reset.
  - Any in-flight operation is dropped with no response.
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid is high, assert req_ready for the winner. The winner is the first valid index scanning last+1, last+2, ... modulo NREQ.
  - On that handshake edge: latch A, B, sub and id; set last=id; go to CALC.
  - With no valid request, stay in IDLE.
- CALC:
  - The registered operands drive the shared adder combinationally.
  - At the edge: register rsp_data and rsp_ovf, set rsp_valid=1, go to RESP.
  - req_ready=0 in this state.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_ovf stay stable until rsp_ready=1.
  - If rsp_ready=0: stay in RESP, req_ready=0.
  - If rsp_ready=1 and no req_valid: clear rsp_valid, go to IDLE.
  - If rsp_ready=1 and a req_valid is present: arbitrate exactly as in IDLE in the same cycle. Accept the winner, clear rsp_valid at the edge, and go to CALC (back-to-back operation).
- Latency and throughput:
  - Handshake in cycle n gives rsp_valid high in cycle n+2.
  - Peak throughput is one operation per 2 cycles.
- Overflow: rsp_ovf=1 exactly when the mathematical A±B (operands as signed WIDTH-bit values) lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Add: ovf = (A[msb]==B[msb]) & (S[msb]!=A[msb]).
  - Sub: ovf = (A[msb]!=B[msb]) & (S[msb]!=A[msb]).
  - Both rules cover B = -2^(WIDTH-1).
- Requester rules:
  - req_valid may only drop after its handshake; a dropped request is a protocol error and does not need to be handled.
  - Operands are sampled only on the handshake edge.
- Priority pointer: moves only on a grant. A requester whose request is not accepted keeps its priority position.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_CALC=2'd1, ST_RESP=2'd2.
  - Default WIDTH/NREQ/IDW constants.
  - A function for the next round-robin winner (one-hot grant from valid vector and last pointer).
- One sub-module: the existing 20-bit carry-lookahead add/sub unit (cla20d), instantiated once.
  - Its subtract-select input is tied to the registered sub bit.
  - The overflow flag is computed in this block from the registered operand MSBs and the adder output.

Test Plan:
- Single add: req 0 with A=0x00005, B=0x00003, sub=0, handshake in cycle n -> rsp_valid in cycle n+2 with rsp_data=0x00008, rsp_id=0, rsp_ovf=0.
- Subtract and overflow:
  - 0x00003-0x00005 -> 0xFFFFE, ovf=0.
  - 0x7FFFF+0x00001 -> 0x80000, ovf=1.
  - 0x80000-0x00001 -> 0x7FFFF, ovf=1.
  - 0x00000-0x80000 -> 0x80000, ovf=1.
- Fairness: all 4 requesters hold valid with rsp_ready=1 -> grant order 0,1,2,3,0,1; new handshakes every 2 cycles; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_valid/rsp_id/rsp_data/rsp_ovf stable, all req_ready=0. Raising rsp_ready with req 2 pending -> response retired and req 2 accepted in the same cycle.
- Skip-idle priority: last grant was 1, only requesters 0 and 3 valid -> 3 is granted before 0.
- Reset mid-CALC: assert rst asynchronously between edges -> outputs zero immediately, no response emitted; the next request from requester 2 (with 0 also valid) grants 0 first.
